// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit controller: FSM state encoding and parity types.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_parity_calc.sv
// Combinational parity generator: even parity is the XOR of all data bits, odd is its inverse.
module uart_parity_calc
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  parity
);

  assign parity = (^data) ^ (par_typ == PAR_ODD);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: serialises a latched word as start, data (LSB first),
// optional parity and one or two stop bits, with back-to-back frame support.
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  output logic                  TX_OUT,
  output logic                  Busy,
  output logic                  DONE
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        bit_cnt, bit_cnt_nxt;
  logic                    stop_cnt, stop_cnt_nxt;
  logic [DATA_WIDTH-1:0]   data_reg;
  logic                    par_bit_reg, par_en_reg, stop2_reg;
  logic                    par_calc;
  logic                    stop_final, accept;
  logic                    tx_nxt, busy_nxt, done_nxt;

  uart_parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_parity (
    .data    (P_DATA),
    .par_typ (PAR_TYP),
    .parity  (par_calc)
  );

  // The final stop cycle is the only point mid-frame where a new request is honoured.
  assign stop_final = (state == ST_STOP) && (!stop2_reg || stop_cnt);
  assign accept     = DATA_VALID && ((state == ST_IDLE) || stop_final);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      TX_OUT   <= 1'b1;
      Busy     <= 1'b0;
      DONE     <= 1'b0;
    end else begin
      state    <= state_nxt;
      bit_cnt  <= bit_cnt_nxt;
      stop_cnt <= stop_cnt_nxt;
      TX_OUT   <= tx_nxt;
      Busy     <= busy_nxt;
      DONE     <= done_nxt;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      data_reg    <= '0;
      par_bit_reg <= 1'b0;
      par_en_reg  <= 1'b0;
      stop2_reg   <= 1'b0;
    end else if (accept) begin
      data_reg    <= P_DATA;
      par_bit_reg <= par_calc;
      par_en_reg  <= PAR_EN;
      stop2_reg   <= STOP2;
    end
  end

  // NOTE: every signal gets a default before the case so no latch can be inferred.
  always_comb begin
    state_nxt = ST_IDLE;
    case (state)
      ST_IDLE:   state_nxt = accept ? ST_START : ST_IDLE;
      ST_START:  state_nxt = ST_DATA;
      ST_DATA: begin
        if (bit_cnt == LAST_BIT) state_nxt = par_en_reg ? ST_PARITY : ST_STOP;
        else                     state_nxt = ST_DATA;
      end
      ST_PARITY: state_nxt = ST_STOP;
      ST_STOP: begin
        if (stop_final) state_nxt = accept ? ST_START : ST_IDLE;
        else            state_nxt = ST_STOP;
      end
      default:   state_nxt = ST_IDLE;
    endcase
    bit_cnt_nxt  = ((state == ST_DATA) && (state_nxt == ST_DATA)) ? bit_cnt + CNT_W'(1) : '0;
    stop_cnt_nxt = (state == ST_STOP) && (state_nxt == ST_STOP);
  end

  // Outputs are decoded from the upcoming state so the registered line matches it cycle-exact.
  always_comb begin
    tx_nxt   = 1'b1;
    busy_nxt = 1'b1;
    done_nxt = 1'b0;
    case (state_nxt)
      ST_IDLE:   busy_nxt = 1'b0;
      ST_START:  tx_nxt   = 1'b0;
      ST_DATA:   tx_nxt   = data_reg[bit_cnt_nxt];
      ST_PARITY: tx_nxt   = par_bit_reg;
      ST_STOP:   done_nxt = !stop2_reg || stop_cnt_nxt;
      default:   busy_nxt = 1'b0;
    endcase
  end

endmodule
